// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: filters the raw PS/2 clock, deframes bytes and turns the arrow keys
// and 'S' into single-cycle command pulses. Receive-only; the PS/2 lines are never driven.
module ps2_key_decoder #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [3:0] direction,
    output logic       start_pulse,
    output logic       byte_valid,
    output logic [7:0] scancode,
    output logic       frame_error
);

    localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // Input synchronizers and glitch filter
    logic           clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic           dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic           filt_q, filt_d;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;

    // Frame receiver
    state_e         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_q, parity_d;
    logic [TCW-1:0] tmo_q, tmo_d;

    // Decoder state; held bits are {start, up, down, left, right}
    logic           ext_q, ext_d, brk_q, brk_d;
    logic [4:0]     held_q, held_d;

    // Registered outputs
    logic [3:0]     direction_q, direction_d;
    logic           start_q, start_d;
    logic           byte_valid_q, byte_valid_d;
    logic [7:0]     scancode_q, scancode_d;
    logic           frame_error_q, frame_error_d;

    // Per-cycle events
    logic           fall, bit_in, good, error, timeout_hit;
    logic [4:0]     key_mask;

    // Next-state logic: filter, receive FSM, timeout and key decode
    always_comb begin
        clk_s1_d      = ps2_clk;
        clk_s2_d      = clk_s1_q;
        dat_s1_d      = ps2_dat;
        dat_s2_d      = dat_s1_q;
        filt_d        = filt_q;
        filt_cnt_d    = filt_cnt_q;
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        tmo_d         = tmo_q;
        ext_d         = ext_q;
        brk_d         = brk_q;
        held_d        = held_q;
        direction_d   = 4'b0000;
        start_d       = 1'b0;
        byte_valid_d  = 1'b0;
        scancode_d    = scancode_q;
        frame_error_d = 1'b0;
        good          = 1'b0;
        error         = 1'b0;
        key_mask      = 5'b00000;

        // Flip the filtered level only after FILTER_LEN consecutive differing samples
        if (clk_s2_q == filt_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
            filt_d     = clk_s2_q;
            filt_cnt_d = '0;
        end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
        end
        fall   = filt_q & ~filt_d;
        bit_in = dat_s2_q;

        // A fall on the terminal-count cycle wins over the timeout
        timeout_hit = (state_q != StIdle) && !fall && (tmo_q == TCW'(TIMEOUT));
        if (state_q == StIdle || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (fall) begin
            case (state_q)
                StIdle: begin
                    if (!bit_in) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end else begin
                        error = 1'b1;
                    end
                end
                StData: begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    parity_d = bit_in;
                    state_d  = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (bit_in && (^{shift_q, parity_q})) begin
                        good = 1'b1;
                    end else begin
                        error = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (timeout_hit) begin
            state_d = StIdle;
            error   = 1'b1;
        end

        if (error) begin
            frame_error_d = 1'b1;
            ext_d         = 1'b0;
            brk_d         = 1'b0;
        end

        if (good) begin
            byte_valid_d = 1'b1;
            scancode_d   = shift_q;
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                case (shift_q)
                    8'h75:   key_mask = ext_q ? 5'b01000 : 5'b00000;
                    8'h72:   key_mask = ext_q ? 5'b00100 : 5'b00000;
                    8'h6B:   key_mask = ext_q ? 5'b00010 : 5'b00000;
                    8'h74:   key_mask = ext_q ? 5'b00001 : 5'b00000;
                    8'h1B:   key_mask = ext_q ? 5'b00000 : 5'b10000;
                    default: key_mask = 5'b00000;
                endcase
                if (key_mask != 5'b00000) begin
                    if (brk_q) begin
                        held_d = held_q & ~key_mask;
                    end else if ((held_q & key_mask) == 5'b00000) begin
                        // First make only; typematic repeats stay silent
                        held_d      = held_q | key_mask;
                        start_d     = key_mask[4];
                        direction_d = key_mask[3:0];
                    end
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset; filter path idles high
    always_ff @(posedge clock) begin
        if (!resetn) begin
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            dat_s1_q      <= 1'b1;
            dat_s2_q      <= 1'b1;
            filt_q        <= 1'b1;
            filt_cnt_q    <= '0;
            state_q       <= StIdle;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            parity_q      <= 1'b0;
            tmo_q         <= '0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            held_q        <= 5'b00000;
            direction_q   <= 4'b0000;
            start_q       <= 1'b0;
            byte_valid_q  <= 1'b0;
            scancode_q    <= 8'h00;
            frame_error_q <= 1'b0;
        end else begin
            clk_s1_q      <= clk_s1_d;
            clk_s2_q      <= clk_s2_d;
            dat_s1_q      <= dat_s1_d;
            dat_s2_q      <= dat_s2_d;
            filt_q        <= filt_d;
            filt_cnt_q    <= filt_cnt_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            tmo_q         <= tmo_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            held_q        <= held_d;
            direction_q   <= direction_d;
            start_q       <= start_d;
            byte_valid_q  <= byte_valid_d;
            scancode_q    <= scancode_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign direction   = direction_q;
    assign start_pulse = start_q;
    assign byte_valid  = byte_valid_q;
    assign scancode    = scancode_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: drives PS/2 frames, predicts each output event in a queue and
// compares every non-idle output cycle against the head of that queue.
module tb_ps2_key_decoder;

    localparam int unsigned FILT = 8;
    localparam int unsigned TMO  = 200;
    localparam int unsigned HALF = 20;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [3:0] direction;
    logic       start_pulse;
    logic       byte_valid;
    logic [7:0] scancode;
    logic       frame_error;

    always #5 clock = ~clock;

    ps2_key_decoder #(
        .FILTER_LEN(FILT),
        .TIMEOUT   (TMO)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .direction  (direction),
        .start_pulse(start_pulse),
        .byte_valid (byte_valid),
        .scancode   (scancode),
        .frame_error(frame_error)
    );

    // Event layout: {byte_valid, frame_error, direction[3:0], start_pulse, scancode[7:0]}
    typedef logic [14:0] evt_t;
    evt_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int up_cnt = 0;
    int start_cnt = 0;

    logic       model_ext = 1'b0;
    logic       model_brk = 1'b0;
    logic [4:0] model_held = 5'b00000;
    logic [7:0] model_sc = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                              input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        ps2_dat = 1'b1;
    endtask

    task automatic model_good(input logic [7:0] b);
        evt_t       e;
        logic [4:0] m;
        e        = {1'b1, 1'b0, 4'b0000, 1'b0, b};
        m        = 5'b00000;
        model_sc = b;
        if (b == 8'hE0) begin
            model_ext = 1'b1;
        end else if (b == 8'hF0) begin
            model_brk = 1'b1;
        end else begin
            if (model_ext) begin
                if (b == 8'h75) m = 5'b01000;
                if (b == 8'h72) m = 5'b00100;
                if (b == 8'h6B) m = 5'b00010;
                if (b == 8'h74) m = 5'b00001;
            end else if (b == 8'h1B) begin
                m = 5'b10000;
            end
            if (m != 5'b00000) begin
                if (model_brk) begin
                    model_held = model_held & ~m;
                end else if ((model_held & m) == 5'b00000) begin
                    model_held = model_held | m;
                    e[12:9]    = m[3:0];
                    e[8]       = m[4];
                end
            end
            model_ext = 1'b0;
            model_brk = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    task automatic model_err();
        model_ext = 1'b0;
        model_brk = 1'b0;
        exp_q.push_back({1'b1 ^ 1'b1, 1'b1, 4'b0000, 1'b0, model_sc});
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick(1);
            n++;
        end
        check_val({tag, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_good(b);
        send_frame(b, 1'b0, 1'b0, 11);
        wait_drain("byte");
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_dir"}, direction, 0);
        check_val({tag, "_start"}, start_pulse, 0);
        check_val({tag, "_valid"}, byte_valid, 0);
        check_val({tag, "_scancode"}, scancode, 0);
        check_val({tag, "_ferr"}, frame_error, 0);
    endtask

    // Scoreboard: every active output cycle must match the oldest prediction
    always @(negedge clock) begin
        evt_t got;
        evt_t exp;
        if (resetn) begin
            got = {byte_valid, frame_error, direction, start_pulse, scancode};
            if (byte_valid || frame_error || (direction != 4'b0000) || start_pulse) begin
                check_val("onehot", ($countones({direction, start_pulse}) <= 1), 1);
                if (exp_q.size() == 0) begin
                    check_val("unexpected_event", got, 0);
                end else begin
                    exp = exp_q.pop_front();
                    check_val("event", got, exp);
                end
                if (direction[3]) up_cnt++;
                if (start_pulse) start_cnt++;
            end
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        resetn = 1'b1;
        tick(5);

        // Clean up arrow
        send_byte(8'hE0);
        send_byte(8'h75);
        check_val("up_first", up_cnt, 1);

        // Typematic repeat, then release and re-press
        send_byte(8'hE0);
        send_byte(8'h75);
        check_val("up_repeat", up_cnt, 1);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check_val("up_release", up_cnt, 1);
        send_byte(8'hE0);
        send_byte(8'h75);
        check_val("up_repress", up_cnt, 2);

        // Remaining keys, keypad form and an unmapped code
        send_byte(8'hE0);
        send_byte(8'h72);
        send_byte(8'hE0);
        send_byte(8'h6B);
        send_byte(8'hE0);
        send_byte(8'h74);
        send_byte(8'h1B);
        send_byte(8'h75);
        send_byte(8'h1C);
        check_val("start_first", start_cnt, 1);
        check_val("up_keypad", up_cnt, 2);

        // Release up, then error frames
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        model_err();
        send_frame(8'h75, 1'b1, 1'b0, 11);
        wait_drain("bad_parity");
        model_err();
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        wait_drain("bad_stop");
        send_byte(8'hE0);
        model_err();
        send_frame(8'h33, 1'b1, 1'b0, 11);
        wait_drain("prefix_err");
        send_byte(8'h75);
        check_val("up_after_err", up_cnt, 2);

        // Release S, then abort a frame by timeout
        send_byte(8'hF0);
        send_byte(8'h1B);
        model_err();
        send_frame(8'h5A, 1'b0, 1'b0, 5);
        tick(TMO + 100);
        wait_drain("timeout");
        send_byte(8'h1B);
        check_val("start_after_tmo", start_cnt, 2);

        // Press up, then reset mid-frame; reset clears held state
        send_byte(8'hE0);
        send_byte(8'h75);
        check_val("up_pre_reset", up_cnt, 3);
        send_frame(8'h75, 1'b0, 1'b0, 6);
        resetn = 1'b0;
        tick(3);
        check_reset_outputs("midreset");
        resetn     = 1'b1;
        model_ext  = 1'b0;
        model_brk  = 1'b0;
        model_held = 5'b00000;
        model_sc   = 8'h00;
        tick(5);
        send_byte(8'hE0);
        send_byte(8'h75);
        check_val("up_post_reset", up_cnt, 4);

        // Short low glitch on ps2_clk with data high must not start or error a frame
        ps2_dat = 1'b1;
        ps2_clk = 1'b0;
        tick(FILT / 2);
        ps2_clk = 1'b1;
        tick(40);
        check_val("glitch_ferr", frame_error, 0);
        send_byte(8'h1B);
        check_val("start_after_glitch", start_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
